grey_capture_readout: RTL and testbench



---
 rtl/grey_capture_readout.sv | 208 ++++++++++++++++++++
 tb/tb_grey_capture_readout.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grey_capture_readout.sv
// grey_capture_readout
//
// Captures one of pCHANNELS asynchronous Johnson-coded decimal counters,
// waits for the selected word to hold still, decodes each 5-bit digit to
// BCD and streams the digits out most-significant first over a
// valid/ready port.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset, clears all state
//   i_data     counter bus, channel c digit d at [(c*pDIGITS+d)*5 +: 5]
//   i_sel      channel select, sampled together with i_capture
//   i_capture  capture request (honoured only while idle)
//   i_ready    consumer accepts the presented digit
//   o_valid    o_nibble/o_idx/o_err carry a digit
//   o_nibble   BCD digit, 4'hF for an invalid code
//   o_idx      index of the presented digit (pDIGITS-1 down to 0)
//   o_err      presented digit had an invalid code
//   o_timeout  word was latched without reaching stability
//   o_busy     a capture/readout is in progress
//   o_done     one-cycle pulse after the last digit is accepted
module grey_capture_readout #(
  parameter int pCHANNELS = 4,
  parameter int pDIGITS   = 3,
  parameter int pSTABLE   = 4,
  parameter int pTIMEOUT  = 1023,
  localparam int SELW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1,
  localparam int IDXW = (pDIGITS > 1) ? $clog2(pDIGITS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [pCHANNELS*pDIGITS*5-1:0] i_data,
  input  logic [SELW-1:0]                i_sel,
  input  logic                           i_capture,
  input  logic                           i_ready,
  output logic                           o_valid,
  output logic [3:0]                     o_nibble,
  output logic [IDXW-1:0]                o_idx,
  output logic                           o_err,
  output logic                           o_timeout,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int WORDW = pDIGITS * 5;
  localparam int BUSW  = pCHANNELS * WORDW;
  localparam int CW    = $clog2(pSTABLE + 1);
  localparam int TW    = $clog2(pTIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, COMPARE, EMIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [BUSW-1:0]   sync_p0, sync_p1;
  logic [SELW-1:0]   sel_q;
  logic              settle_cnt;
  logic [CW-1:0]     match_cnt, match_nxt;
  logic [TW-1:0]     to_cnt, to_nxt;
  logic [WORDW-1:0]  word, prev_word, cap_word;
  logic [4:0]        dig_next;
  logic              latch, latch_to;

  // Returns {err, bcd}; anything outside the ten legal Johnson states is an error.
  function automatic logic [4:0] dec_johnson(input logic [4:0] code);
    logic [4:0] r;
    case (code)
      5'b00000: r = {1'b0, 4'd0};
      5'b00001: r = {1'b0, 4'd1};
      5'b00011: r = {1'b0, 4'd2};
      5'b00111: r = {1'b0, 4'd3};
      5'b01111: r = {1'b0, 4'd4};
      5'b11111: r = {1'b0, 4'd5};
      5'b11110: r = {1'b0, 4'd6};
      5'b11100: r = {1'b0, 4'd7};
      5'b11000: r = {1'b0, 4'd8};
      5'b10000: r = {1'b0, 4'd9};
      default:  r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // Out-of-range selects wrap around rather than reading a missing channel.
  function automatic logic [SELW-1:0] sel_mod(input logic [SELW-1:0] s);
    int v;
    v = int'(s) % pCHANNELS;
    return v[SELW-1:0];
  endfunction

  // Channel mux after the synchroniser
  always_comb begin
    word = '0;
    for (int c = 0; c < pCHANNELS; c++)
      if (sel_q == SELW'(c)) word = sync_p1[c*WORDW +: WORDW];
  end

  // Digit that follows the one currently presented (index o_idx-1)
  always_comb begin
    dig_next = '0;
    for (int d = 0; d < pDIGITS; d++)
      if (int'(o_idx) == d + 1) dig_next = cap_word[d*5 +: 5];
  end

  // Next-state and stability/timeout counting
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    to_nxt    = to_cnt;
    latch     = 1'b0;
    latch_to  = 1'b0;
    case (state)
      IDLE:    if (i_capture) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt) state_nxt = COMPARE;
      COMPARE: begin
        // match_cnt is zero only on the first COMPARE cycle, which counts as 1.
        if (match_cnt == '0 || word != prev_word) match_nxt = CW'(1);
        else                                       match_nxt = match_cnt + CW'(1);
        to_nxt = to_cnt + TW'(1);
        if (match_nxt == CW'(pSTABLE)) begin
          latch     = 1'b1;
          state_nxt = EMIT;
        end else if (to_nxt == TW'(pTIMEOUT)) begin
          latch     = 1'b1;
          latch_to  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT:    if (o_valid && i_ready && o_idx == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      sel_q      <= '0;
      settle_cnt <= 1'b0;
      match_cnt  <= '0;
      to_cnt     <= '0;
      prev_word  <= '0;
      cap_word   <= '0;
      o_valid    <= 1'b0;
      o_nibble   <= '0;
      o_idx      <= '0;
      o_err      <= 1'b0;
      o_timeout  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchroniser on the whole bus
      sync_p0 <= i_data;
      sync_p1 <= sync_p0;

      // Control / readout stage
      case (state)
        IDLE: begin
          if (i_capture) begin
            sel_q      <= sel_mod(i_sel);
            settle_cnt <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        SETTLE: begin
          settle_cnt <= 1'b1;
          match_cnt  <= '0;
          to_cnt     <= '0;
        end
        COMPARE: begin
          prev_word <= word;
          match_cnt <= match_nxt;
          to_cnt    <= to_nxt;
          if (latch) begin
            cap_word              <= word;
            o_valid               <= 1'b1;
            o_idx                 <= IDXW'(pDIGITS - 1);
            {o_err, o_nibble}     <= dec_johnson(word[WORDW-5 +: 5]);
            o_timeout             <= latch_to;
          end
        end
        EMIT: begin
          if (i_ready) begin
            if (o_idx == '0) begin
              o_valid  <= 1'b0;
              o_done   <= 1'b1;
              o_nibble <= '0;
              o_err    <= 1'b0;
            end else begin
              o_idx             <= o_idx - IDXW'(1);
              {o_err, o_nibble} <= dec_johnson(dig_next);
            end
          end
        end
        DONE: begin
          o_done    <= 1'b0;
          o_timeout <= 1'b0;
          o_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grey_capture_readout.sv
// tb_grey_capture_readout
//
// Directed bench for grey_capture_readout (4 channels, 3 digits,
// pSTABLE=4, pTIMEOUT=20). Expected digits, latencies and flags are
// written out by hand for each scenario.
module tb_grey_capture_readout;

  localparam int NCH  = 4;
  localparam int NDIG = 3;
  localparam int NSTB = 4;
  localparam int NTO  = 20;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NCH*NDIG*5-1:0] data;
  logic [1:0]            sel;
  logic                  capture;
  logic                  ready;
  logic                  valid;
  logic [3:0]            nibble;
  logic [1:0]            idx;
  logic                  err;
  logic                  tmo;
  logic                  busy;
  logic                  done;

  int nvec = 0;
  int nmis = 0;

  logic [4:0] jc [10];
  int         exp_nib [NDIG];
  int         exp_err [NDIG];
  int         exp_to;
  bit         d0_either;

  always #5 clk = ~clk;

  grey_capture_readout #(
    .pCHANNELS(NCH),
    .pDIGITS  (NDIG),
    .pSTABLE  (NSTB),
    .pTIMEOUT (NTO)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (data),
    .i_sel    (sel),
    .i_capture(capture),
    .i_ready  (ready),
    .o_valid  (valid),
    .o_nibble (nibble),
    .o_idx    (idx),
    .o_err    (err),
    .o_timeout(tmo),
    .o_busy   (busy),
    .o_done   (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digit(input int ch, input int d, input logic [4:0] code);
    data[(ch*NDIG+d)*5 +: 5] = code;
  endtask

  // Leaves the bench in cycle 1 (the cycle after the sampling edge).
  task automatic start_capture(input logic [1:0] s, output int c);
    sel     = s;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    c = 1;
  endtask

  task automatic wait_valid(input int c0, output int c);
    c = c0;
    while (!valid && c < 60) begin
      tick();
      c++;
    end
  endtask

  // Walks the three digits from the first valid cycle, optionally stalling
  // at idx 1, then checks the DONE pulse and the return to idle.
  task automatic drain(input int stall, input bit poke_done, input int c0, output int cdone);
    int c;
    c = c0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      if (k == 1 && stall > 0) begin
        ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          check_eq("hold_valid", valid, 1);
          check_eq("hold_idx", idx, 1);
          check_eq("hold_nibble", nibble, exp_nib[1]);
          tick();
          c++;
        end
        ready = 1'b1;
      end
      check_eq("valid", valid, 1);
      check_eq("idx", idx, k);
      if (k == 0 && d0_either) check_eq("nibble_d0_1or2", (nibble == 4'd1 || nibble == 4'd2), 1);
      else                     check_eq("nibble", nibble, exp_nib[k]);
      check_eq("err", err, exp_err[k]);
      check_eq("timeout", tmo, exp_to);
      tick();
      c++;
    end
    check_eq("done_pulse", done, 1);
    check_eq("done_valid", valid, 0);
    cdone = c;
    if (poke_done) begin
      sel     = 2'd0;
      capture = 1'b1;
    end
    tick();
    capture = 1'b0;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);
    check_eq("idle_timeout", tmo, 0);
    tick();
    check_eq("idle_busy2", busy, 0);
  endtask

  initial begin
    int c;
    int cd;
    int t;
    jc = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
           5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
    data    = '0;
    sel     = '0;
    capture = 1'b0;
    ready   = 1'b1;
    // ch0 = 0-0-1, ch1 = 8-5-<bad>, ch2 = 4-7-9, ch3 = 6-0-3
    set_digit(0, 2, jc[0]); set_digit(0, 1, jc[0]); set_digit(0, 0, jc[1]);
    set_digit(1, 2, jc[8]); set_digit(1, 1, jc[5]); set_digit(1, 0, 5'b10101);
    set_digit(2, 2, jc[4]); set_digit(2, 1, jc[7]); set_digit(2, 0, jc[9]);
    set_digit(3, 2, jc[6]); set_digit(3, 1, jc[0]); set_digit(3, 0, jc[3]);

    // Asynchronous reset mid-cycle, then idle with no capture
    #3 rst_n = 1'b0;
    #1 check_eq("rst_async_outputs", {valid, nibble, idx, err, tmo, busy, done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("idle_outputs", {valid, nibble, idx, err, tmo, busy, done}, 0);
    end

    // Stable capture of ch2
    exp_nib = '{9, 7, 4};
    exp_err = '{0, 0, 0};
    exp_to    = 0;
    d0_either = 1'b0;
    start_capture(2'd2, c);
    check_eq("busy_after_capture", busy, 1);
    wait_valid(c, c);
    check_eq("stable_first_valid_cycle", c, 7);
    drain(0, 1'b0, c, cd);
    check_eq("stable_done_cycle", cd, 10);

    // Backpressure at idx 1 for 5 cycles
    start_capture(2'd2, c);
    wait_valid(c, c);
    check_eq("bp_first_valid_cycle", c, 7);
    drain(5, 1'b0, c, cd);
    check_eq("bp_done_cycle", cd, 15);

    // Unstable ch0 digit 0 toggling 1 <-> 2 every 2 cycles
    exp_nib = '{1, 0, 0};
    exp_err = '{0, 0, 0};
    exp_to    = 1;
    d0_either = 1'b1;
    start_capture(2'd0, c);
    t = 0;
    while (!valid && c < 80) begin
      tick();
      c++;
      t++;
      if (t % 2 == 0) begin
        if (data[0 +: 5] == jc[1]) set_digit(0, 0, jc[2]);
        else                       set_digit(0, 0, jc[1]);
      end
    end
    check_eq("timeout_first_valid_cycle", c, 3 + NTO);
    drain(0, 1'b0, c, cd);
    set_digit(0, 0, jc[1]);

    // Invalid code on ch1 digit 0
    exp_nib = '{15, 5, 8};
    exp_err = '{1, 0, 0};
    exp_to    = 0;
    d0_either = 1'b0;
    start_capture(2'd1, c);
    wait_valid(c, c);
    check_eq("bad_first_valid_cycle", c, 7);
    drain(0, 1'b0, c, cd);

    // Reset in the middle of EMIT at idx 1
    start_capture(2'd3, c);
    wait_valid(c, c);
    tick();
    check_eq("pre_reset_idx", idx, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("mid_emit_rst_outputs", {valid, nibble, idx, err, tmo, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_valid", valid, 0);

    // Fresh capture of ch3 with a stray capture while busy and in DONE
    exp_nib = '{3, 0, 6};
    exp_err = '{0, 0, 0};
    start_capture(2'd3, c);
    tick();
    tick();
    c = 3;
    sel     = 2'd0;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    c = 4;
    wait_valid(c, c);
    check_eq("recap_first_valid_cycle", c, 7);
    drain(0, 1'b1, c, cd);
    check_eq("recap_done_cycle", cd, 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
